temp_stack: RTL and testbench

- Parametrised successor to the processor's single 16-bit temporary register.
- Holds up to DEPTH temporaries in LIFO order: push, pop, and overwrite-top (loadTemp).
- The registered top-of-stack always drives saida, so the datapath reads the most recent temporary with no extra cycle.
- Occupancy and error flags go to the control unit for nested expression evaluation.

---
 rtl/temp_stack_if.sv | 41 ++++
 rtl/temp_stack.sv | 110 +++++++++++
 tb/tb_temp_stack.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/temp_stack_if.sv
// temp_stack_if: command/data bundle between the control unit and temp_stack.
// Optional macro TEMP_STACK_STICKY_ERR_EN adds the err_clr line.
//
// Handshake: no valid/ready pair. A command (push, pop, loadTemp) is taken
// on every rising edge where it is asserted. The slave's outputs are all
// registered, so they always show the state after the last edge.
interface temp_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic             loadTemp;
  logic [WIDTH-1:0] entrada;
  logic [WIDTH-1:0] saida;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             erro;
`ifdef TEMP_STACK_STICKY_ERR_EN
  logic             err_clr;
`endif

  modport master (
    output push, pop, loadTemp, entrada,
`ifdef TEMP_STACK_STICKY_ERR_EN
    output err_clr,
`endif
    input  saida, count, empty, full, erro
  );

  modport slave (
    input  push, pop, loadTemp, entrada,
`ifdef TEMP_STACK_STICKY_ERR_EN
    input  err_clr,
`endif
    output saida, count, empty, full, erro
  );
endinterface

// File: rtl/temp_stack.sv
// temp_stack: LIFO of DEPTH temporaries with a registered top-of-stack.
// Commands in priority order: replace (push&pop or loadTemp), push, pop.
// Overflow/underflow are refused and reported on erro.
// Optional macro TEMP_STACK_STICKY_ERR_EN: erro is sticky until reset or
// err_clr, and a new error on the same edge wins over err_clr.
// DEPTH must be at least 2.
module temp_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  temp_stack_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] saida_q, saida_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             erro_q, erro_d;

  logic             do_replace;
  logic             illegal;
  logic [CW-1:0]    cnt_m1;
  logic [CW-1:0]    cnt_m2;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    below_idx;

  // Index arithmetic; every use is guarded by the full/empty/count checks
  // below, so the truncation to AW bits never drops a meaningful bit.
  assign cnt_m1    = count_q - CW'(1);
  assign cnt_m2    = count_q - CW'(2);
  assign wr_idx    = AW'(count_q);
  assign top_idx   = AW'(cnt_m1);
  assign below_idx = AW'(cnt_m2);

  // Decode the command and compute the next stack contents, top and flags.
  always_comb begin
    mem_d      = mem_q;
    count_d    = count_q;
    saida_d    = saida_q;
    illegal    = 1'b0;
    do_replace = (bus.push & bus.pop) | bus.loadTemp;

    if (do_replace) begin
      if (count_q != '0) begin
        mem_d[top_idx] = bus.entrada;
      end else begin
        mem_d[wr_idx] = bus.entrada;
        count_d       = count_q + CW'(1);
      end
      saida_d = bus.entrada;
    end else if (bus.push) begin
      if (!full_q) begin
        mem_d[wr_idx] = bus.entrada;
        count_d       = count_q + CW'(1);
        saida_d       = bus.entrada;
      end else begin
        illegal = 1'b1;
      end
    end else if (bus.pop) begin
      if (!empty_q) begin
        // The popped entry is left in place; only the count moves.
        count_d = cnt_m1;
        saida_d = (count_q > CW'(1)) ? mem_q[below_idx] : '0;
      end else begin
        illegal = 1'b1;
      end
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));

`ifdef TEMP_STACK_STICKY_ERR_EN
    erro_d = illegal | (erro_q & ~bus.err_clr);
`else
    erro_d = illegal;
`endif
  end

  // State registers; synchronous reset clears everything including storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      saida_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      saida_q <= saida_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      erro_q  <= erro_d;
    end
  end

  assign bus.saida = saida_q;
  assign bus.count = count_q;
  assign bus.empty = empty_q;
  assign bus.full  = full_q;
  assign bus.erro  = erro_q;
endmodule

// File: tb/tb_temp_stack.sv
// tb_temp_stack: directed plus random stimulus for temp_stack (DEPTH=4),
// checked against a queue-based LIFO model through an expected-value queue.
module tb_temp_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int W     = WIDTH + CW + 3;

  logic clk;
  logic reset;

  temp_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  temp_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] stk [$];
  logic             m_err;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  int           n_tests;
  int           n_fail;

  function automatic logic [W-1:0] model_outputs();
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    cnt;
    top = (stk.size() != 0) ? stk[stk.size() - 1] : '0;
    cnt = CW'(stk.size());
    return {top, cnt, stk.size() == 0, stk.size() == DEPTH, m_err};
  endfunction

  // One clock of stimulus: drive inputs, advance the model, queue expectation.
  task automatic step(input logic r, input logic p, input logic o,
                      input logic l, input logic [WIDTH-1:0] d,
                      input logic c);
    logic illegal;
    @(negedge clk);
    reset        = r;
    bus.push     = p;
    bus.pop      = o;
    bus.loadTemp = l;
    bus.entrada  = d;
`ifdef TEMP_STACK_STICKY_ERR_EN
    bus.err_clr  = c;
`endif
    illegal = 1'b0;
    if (r) begin
      stk.delete();
      m_err = 1'b0;
    end else begin
      if ((p && o) || l) begin
        if (stk.size() != 0) stk[stk.size() - 1] = d;
        else                 stk.push_back(d);
      end else if (p) begin
        if (stk.size() < DEPTH) stk.push_back(d);
        else                    illegal = 1'b1;
      end else if (o) begin
        if (stk.size() != 0) void'(stk.pop_back());
        else                 illegal = 1'b1;
      end
`ifdef TEMP_STACK_STICKY_ERR_EN
      m_err = illegal || (m_err && !c);
`else
      m_err = illegal;
`endif
    end
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_push(input logic [WIDTH-1:0] d);
    step(1'b0, 1'b1, 1'b0, 1'b0, d, 1'b0);
  endtask

  task automatic do_pop();
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  // Monitor: outputs are registered and valid every cycle, sampled 1 after the edge.
  always @(posedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    #1;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = {bus.saida, bus.count, bus.empty, bus.full, bus.erro};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs @%0t saida/count/empty/full/erro got %h/%0d/%b/%b/%b expected %h/%0d/%b/%b/%b",
                 $time,
                 act_v[W-1 -: WIDTH], act_v[CW+2:3], act_v[2], act_v[1], act_v[0],
                 exp_v[W-1 -: WIDTH], exp_v[CW+2:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    n_tests      = 0;
    n_fail       = 0;
    m_err        = 1'b0;
    reset        = 1'b1;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.loadTemp = 1'b0;
    bus.entrada  = '0;
`ifdef TEMP_STACK_STICKY_ERR_EN
    bus.err_clr  = 1'b0;
`endif

    // Reset then idle.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(5);

    // Fill, overflow, drain, underflow.
    do_push(16'h1111);
    do_push(16'h2222);
    do_push(16'h3333);
    do_push(16'h4444);
    do_push(16'hDEAD);
    idle(1);
    for (int i = 0; i < 4; i++) do_pop();
    do_pop();
    idle(1);

    // Replace on a two-entry stack, then on an empty one.
    do_push(16'h00AA);
    do_push(16'h00BB);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0CCC, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0DDD, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0EEE, 1'b0);
    do_pop();
    do_pop();
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0);

    // Reset together with a push: nothing is stored.
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0);
    idle(1);
    do_pop();
    idle(1);

`ifdef TEMP_STACK_STICKY_ERR_EN
    // Sticky error: hold, clear, and error winning over clear.
    do_pop();
    idle(10);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
`endif

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      logic r, p, o, l, c;
      r = ($urandom_range(0, 49) == 0);
      p = ($urandom_range(0, 99) < 45);
      o = ($urandom_range(0, 99) < 40);
      l = ($urandom_range(0, 99) < 10);
      c = ($urandom_range(0, 9) == 0);
      step(r, p, o, l, WIDTH'($urandom), c);
    end
    idle(2);

    // Let the monitor drain the queue, bounded.
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain %0d expectations left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
